phoneme_sample_player: RTL

//  Downstream stage of the speech controller. On start_phoneme_output it looks up the selected

---
 rtl/phoneme_sample_player.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/phoneme_sample_player.sv
// Phoneme sample player: looks up a phoneme descriptor (start, length) and streams its
// 8-bit PCM samples from sample memory to the DAC, one sample per sample-rate tick.
module phoneme_sample_player #(
  parameter int ADDR_W       = 23,
  parameter int LEN_W        = 16,
  parameter int NUM_PHONEMES = 64,
  parameter int CLK_HZ       = 50_000_000,
  parameter int SAMPLE_HZ    = 8_000
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start_phoneme_output,
  input  logic [7:0]        phoneme_sel,
  output logic              phoneme_speech_busy,
  output logic [7:0]        tbl_index,
  input  logic [ADDR_W-1:0] tbl_start,
  input  logic [LEN_W-1:0]  tbl_len,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        audio_sample,
  output logic              audio_strobe
);

  localparam int              DIV      = CLK_HZ / SAMPLE_HZ;
  localparam int              DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [8:0]      NUM_P9   = 9'(NUM_PHONEMES);
  localparam logic [7:0]      MIDSCALE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_LOAD,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [7:0]          index_q, index_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [7:0]          buffer_q, buffer_d;
  logic [7:0]          sample_q, sample_d;
  logic                strobe_q, strobe_d;
  logic                tick;
  logic                sel_out_of_range;

  // Free-running sample-rate divider; playback state never pauses it.
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  assign sel_out_of_range = ({1'b0, index_q} >= NUM_P9);

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no branch of
    // the case below can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    index_d     = index_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    buffer_d    = buffer_q;
    sample_d    = sample_q;
    strobe_d    = 1'b0;
    mem_rd_req  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_phoneme_output) begin
          index_d = phoneme_sel;
          busy_d  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_LOAD;
      S_LOAD: begin
        addr_d      = tbl_start;
        remaining_d = tbl_len;
        state_d     = (tbl_len == '0 || sel_out_of_range) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        mem_rd_req = 1'b1;
        if (mem_rd_valid) begin
          buffer_d = mem_rd_data;
          addr_d   = addr_q + 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A tick seen in FETCH is simply missed; the sample waits here for the next one.
        if (tick) begin
          sample_d    = buffer_q;
          strobe_d    = 1'b1;
          remaining_d = (remaining_q == '0) ? '0 : remaining_q - 1'b1;
          state_d     = (remaining_q <= LEN_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        if (tick) begin
          sample_d = MIDSCALE;
          strobe_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      index_q     <= '0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      buffer_q    <= '0;
      sample_q    <= MIDSCALE;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      index_q     <= index_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      buffer_q    <= buffer_d;
      sample_q    <= sample_d;
      strobe_q    <= strobe_d;
    end
  end

  assign phoneme_speech_busy = busy_q;
  assign tbl_index           = index_q;
  assign mem_addr            = addr_q;
  assign audio_sample        = sample_q;
  assign audio_strobe        = strobe_q;

endmodule
